// File: rtl/kbd_event_fifo.sv
// PS/2 scan-byte decoder with typematic filter, press counter and event FIFO.
// Define KBD_EVENT_ASCII_EN to build the head-event ASCII lookup.
module kbd_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_code,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_code,
  output logic       out_break,
  output logic       out_ext,
  output logic [7:0] out_ascii,
  output logic       key_down,
  output logic [7:0] press_cnt,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  state_t state, state_nxt;

  logic ev_vld;
  logic ev_brk;
  logic ev_ext;
  logic is_f0;
  logic is_e0;

  assign is_f0 = (in_code == 8'hF0);
  assign is_e0 = (in_code == 8'hE0);

  always_comb begin
    state_nxt = state;
    ev_vld    = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;
    if (in_valid) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_f0:   state_nxt = BRK;
            is_e0:   state_nxt = EXT;
            default: ev_vld = 1'b1;
          endcase
        end
        EXT: begin
          if (is_f0) begin
            state_nxt = EXT_BRK;
          end else begin
            ev_vld    = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          ev_vld    = 1'b1;
          ev_brk    = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          ev_vld    = 1'b1;
          ev_brk    = 1'b1;
          ev_ext    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Held key tracking and typematic filter
  logic [8:0] held;
  logic       held_hit;
  logic       is_rpt;
  logic       push;
  logic       press;

  assign held_hit = (held == {ev_ext, in_code});
  assign is_rpt   = ev_vld & ~ev_brk & key_down & held_hit;
  assign push     = ev_vld & ~is_rpt;
  assign press    = push & ~ev_brk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= '0;
      key_down  <= 1'b0;
      press_cnt <= '0;
    end else if (press) begin
      held      <= {ev_ext, in_code};
      key_down  <= 1'b1;
      press_cnt <= press_cnt + 8'd1;
    end else if (push && held_hit) begin
      key_down  <= 1'b0;
    end
  end

  // Event FIFO: {ext, break, code}
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [9:0]    head;

  assign full      = (cnt == FULL);
  assign out_valid = (cnt != '0);
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ev_ext, ev_brk, in_code};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_code  = out_valid ? head[7:0] : 8'h00;
  assign out_break = out_valid & head[8];
  assign out_ext   = out_valid & head[9];

`ifdef KBD_EVENT_ASCII_EN
  logic [7:0] asc;

  always_comb begin
    asc = 8'h00;
    unique case (out_code)
      8'h1C: asc = 8'h61;
      8'h32: asc = 8'h62;
      8'h21: asc = 8'h63;
      8'h23: asc = 8'h64;
      8'h24: asc = 8'h65;
      8'h2B: asc = 8'h66;
      8'h34: asc = 8'h67;
      8'h33: asc = 8'h68;
      8'h43: asc = 8'h69;
      8'h3B: asc = 8'h6A;
      8'h42: asc = 8'h6B;
      8'h4B: asc = 8'h6C;
      8'h3A: asc = 8'h6D;
      8'h31: asc = 8'h6E;
      8'h44: asc = 8'h6F;
      8'h4D: asc = 8'h70;
      8'h15: asc = 8'h71;
      8'h2D: asc = 8'h72;
      8'h1B: asc = 8'h73;
      8'h2C: asc = 8'h74;
      8'h3C: asc = 8'h75;
      8'h2A: asc = 8'h76;
      8'h1D: asc = 8'h77;
      8'h22: asc = 8'h78;
      8'h35: asc = 8'h79;
      8'h1A: asc = 8'h7A;
      8'h45: asc = 8'h30;
      8'h16: asc = 8'h31;
      8'h1E: asc = 8'h32;
      8'h26: asc = 8'h33;
      8'h25: asc = 8'h34;
      8'h2E: asc = 8'h35;
      8'h36: asc = 8'h36;
      8'h3D: asc = 8'h37;
      8'h3E: asc = 8'h38;
      8'h46: asc = 8'h39;
      8'h29: asc = 8'h20;
      8'h5A: asc = 8'h0D;
      default: asc = 8'h00;
    endcase
  end

  assign out_ascii = out_ext ? 8'h00 : asc;
`else
  assign out_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Randomized and directed bench for kbd_event_fifo against a queue model.
// Honours KBD_EVENT_ASCII_EN the same way the design does.
module tb_kbd_event_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_code = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_code;
  logic       out_break;
  logic       out_ext;
  logic [7:0] out_ascii;
  logic       key_down;
  logic [7:0] press_cnt;
  logic       overflow;

  kbd_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_break (out_break),
    .out_ext   (out_ext),
    .out_ascii (out_ascii),
    .key_down  (key_down),
    .press_cnt (press_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  bit [9:0] q[$];
  bit       m_brk;
  bit       m_ext;
  bit [8:0] m_held;
  bit       m_down;
  bit [7:0] m_cnt;
  bit       m_ovf;

  function automatic bit [7:0] ref_ascii(bit ext, bit [7:0] c);
`ifdef KBD_EVENT_ASCII_EN
    bit [7:0] let_tab[26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    bit [7:0] dig_tab[10] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (c == let_tab[i]) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++)
      if (c == dig_tab[i]) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  function automatic void model_reset();
    q.delete();
    m_brk  = 0;
    m_ext  = 0;
    m_held = '0;
    m_down = 0;
    m_cnt  = '0;
    m_ovf  = 0;
  endfunction

  function automatic void model_emit(bit e, bit b, bit [7:0] c, int sz, bit pop);
    if (!b && m_down && m_held == {e, c}) return;
    if (!b) begin
      m_held = {e, c};
      m_down = 1;
      m_cnt  = m_cnt + 8'd1;
    end else if (m_held == {e, c}) begin
      m_down = 0;
    end
    if (sz == DEPTH && !pop) m_ovf = 1;
    else q.push_back({e, b, c});
  endfunction

  function automatic void model_step(bit v, bit [7:0] c, bit r);
    int sz  = q.size();
    bit pop = (sz != 0) && r;
    if (pop) void'(q.pop_front());
    if (!v) return;
    if (!m_brk && c == 8'hF0) begin
      m_brk = 1;
    end else if (!m_brk && !m_ext && c == 8'hE0) begin
      m_ext = 1;
    end else begin
      model_emit(m_ext, m_brk, c, sz, pop);
      m_brk = 0;
      m_ext = 0;
    end
  endfunction

  task automatic check_outs(string tag);
    bit [9:0] h = (q.size() != 0) ? q[0] : 10'h0;
    check({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({tag, ".code"}, 32'(out_code), 32'(h[7:0]));
    check({tag, ".brk"}, 32'(out_break), 32'(h[8]));
    check({tag, ".ext"}, 32'(out_ext), 32'(h[9]));
    check({tag, ".ascii"}, 32'(out_ascii), 32'(ref_ascii(h[9], h[7:0])));
    check({tag, ".down"}, 32'(key_down), 32'(m_down));
    check({tag, ".cnt"}, 32'(press_cnt), 32'(m_cnt));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(bit v, logic [7:0] c, bit r, string tag);
    @(negedge clk);
    check_outs(tag);
    in_valid  = v;
    in_code   = c;
    out_ready = r;
    @(posedge clk);
    model_step(v, c, r);
  endtask

  task automatic check_zero(string tag);
    check({tag, ".valid"}, 32'(out_valid), 0);
    check({tag, ".code"}, 32'(out_code), 0);
    check({tag, ".brk"}, 32'(out_break), 0);
    check({tag, ".ext"}, 32'(out_ext), 0);
    check({tag, ".ascii"}, 32'(out_ascii), 0);
    check({tag, ".down"}, 32'(key_down), 0);
    check({tag, ".cnt"}, 32'(press_cnt), 0);
    check({tag, ".ovf"}, 32'(overflow), 0);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    in_valid  = 1'b1;
    in_code   = 8'h1C;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    check_zero({tag, ".async"});
    @(posedge clk);
    #1;
    check_zero({tag, ".held"});
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
  endtask

  task automatic idle(int n, bit r, string tag);
    for (int i = 0; i < n; i++) step(0, 8'h00, r, tag);
  endtask

  logic [7:0] keys9[9] = '{
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  logic [7:0] pool[10] = '{
    8'hF0, 8'hE0, 8'h1C, 8'h75, 8'h29, 8'h45, 8'h5A, 8'h32, 8'hF0, 8'h1C};

  initial begin
    model_reset();
    do_reset("rst0");

    step(1, 8'h1C, 1, "a_press");
    step(1, 8'hF0, 1, "a_f0");
    step(1, 8'h1C, 1, "a_rel");
    idle(3, 1, "a_idle");

    for (int i = 0; i < 5; i++) step(1, 8'h1C, 1, "rpt");
    step(1, 8'hF0, 1, "rpt_f0");
    step(1, 8'h1C, 1, "rpt_rel");
    idle(3, 1, "rpt_idle");

    step(1, 8'hE0, 1, "x_e0");
    step(1, 8'h75, 1, "x_press");
    step(1, 8'hE0, 1, "x_e0b");
    step(1, 8'hF0, 1, "x_f0");
    step(1, 8'h75, 1, "x_rel");
    idle(3, 1, "x_idle");

    do_reset("rst1");
    for (int i = 0; i < 9; i++) step(1, keys9[i], 0, "ovf_fill");
    step(0, 8'h00, 0, "ovf_hold");
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_cnt", 32'(press_cnt), 9);
    idle(10, 1, "ovf_drain");

    do_reset("rst2");
    for (int i = 0; i < 8; i++) step(1, keys9[i], 0, "full_fill");
    step(1, keys9[8], 1, "full_pp");
    step(0, 8'h00, 0, "full_hold");
    check("full_noovf", 32'(overflow), 0);
    idle(10, 1, "full_drain");

    step(1, 8'hF0, 1, "mid_f0");
    do_reset("rst3");
    step(1, 8'h1C, 1, "mid_press");
    step(0, 8'h00, 0, "mid_head");
    check("mid_code", 32'(out_code), 32'h1C);
    check("mid_brk", 32'(out_break), 0);
    idle(2, 1, "mid_idle");

    for (int i = 0; i < 800; i++) begin
      bit v = ($urandom_range(0, 3) != 0);
      logic [7:0] c = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                      : pool[$urandom_range(0, 9)];
      bit r = ($urandom_range(0, 2) == 0);
      step(v, c, r, "rnd");
    end
    idle(12, 1, "rnd_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
